// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : EX-stage sequencer for the shared multi-cycle radix-2
//               divider (div.w / div.wu / mod.w / mod.wu). Latches the
//               operands, drives the divider start/cancel/signed handshake,
//               stalls the pipeline while the divider runs, selects quotient
//               or remainder, and drains the divider after a pipeline flush.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_valid_i          EX-stage instruction valid
//   div_req_i           instruction is a divide/modulo
//   div_op_i[1:0]       00 div.w, 01 div.wu, 10 mod.w, 11 mod.wu
//   src1_i / src2_i     dividend / divisor
//   flush_i             pipeline flush (exception / branch kill)
//   stall_o             hold EX and earlier stages
//   result_o            quotient or remainder (held until next capture)
//   result_valid_o      one-cycle result strobe
//   div_start_o         divider start
//   div_cancel_o        divider cancel
//   div_signed_o        divider signed_op
//   div_op1_o/op2_o     latched operands to divider
//   div_result_i        {remainder, quotient} from divider
//   div_done_i          divider done
// Configuration:
//   DIV_CACHE_EN        when defined, a one-entry result cache lets a repeat
//                       of the last operands (div or mod) skip the divider.
// ============================================================================
module div_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic        div_req_i,
  input  logic [1:0]  div_op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic        result_valid_o,
  output logic        div_start_o,
  output logic        div_cancel_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_done_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [1:0]       state_q, state_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic             signed_q, signed_d;
  logic             sel_rem_q, sel_rem_d;
  logic             start_q, start_d;
  logic [31:0]      result_q, result_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;

  logic w_req;
  logic w_req_signed;
  logic w_accept;

  assign w_req        = ex_valid_i & div_req_i;
  assign w_req_signed = ~div_op_i[0];
  assign w_accept     = w_req & ~flush_i;

`ifdef DIV_CACHE_EN
  logic        cache_vld_q;
  logic [31:0] cache_op1_q;
  logic [31:0] cache_op2_q;
  logic        cache_signed_q;
  logic [63:0] cache_res_q;
  logic        w_hit;

  // sel_rem is not part of the tag: the cache holds both halves, so div and
  // mod of the same operands hit each other.
  assign w_hit = cache_vld_q & (cache_op1_q == src1_i) & (cache_op2_q == src2_i)
               & (cache_signed_q == w_req_signed);

  // Filled only on a clean BUSY->DONE; flush leaves the entry intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q    <= 1'b0;
      cache_op1_q    <= '0;
      cache_op2_q    <= '0;
      cache_signed_q <= 1'b0;
      cache_res_q    <= '0;
    end else if (state_q == S_BUSY && div_done_i && !flush_i) begin
      cache_vld_q    <= 1'b1;
      cache_op1_q    <= op1_q;
      cache_op2_q    <= op2_q;
      cache_signed_q <= signed_q;
      cache_res_q    <= div_result_i;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    signed_d    = signed_q;
    sel_rem_d   = sel_rem_q;
    start_d     = start_q;
    result_d    = result_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          op1_d     = src1_i;
          op2_d     = src2_i;
          signed_d  = w_req_signed;
          sel_rem_d = div_op_i[1];
`ifdef DIV_CACHE_EN
          if (w_hit) begin
            result_d = div_op_i[1] ? cache_res_q[63:32] : cache_res_q[31:0];
            state_d  = S_DONE;
          end else begin
            start_d = 1'b1;
            state_d = S_BUSY;
          end
`else
          start_d = 1'b1;
          state_d = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        // Flush wins over a coincident done: the result is dropped and the
        // divider is walked back to Free through DRAIN.
        if (flush_i) begin
          start_d     = 1'b0;
          drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
          state_d     = S_DRAIN;
        end else if (div_done_i) begin
          result_d = sel_rem_q ? div_result_i[63:32] : div_result_i[31:0];
          start_d  = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      signed_q    <= 1'b0;
      sel_rem_q   <= 1'b0;
      start_q     <= 1'b0;
      result_q    <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      signed_q    <= signed_d;
      sel_rem_q   <= sel_rem_d;
      start_q     <= start_d;
      result_q    <= result_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign stall_o        = ((state_q == S_IDLE) & w_accept) | (state_q == S_BUSY);
  assign result_valid_o = (state_q == S_DONE) & ~flush_i;
  assign div_start_o    = start_q;
  assign div_cancel_o   = (state_q == S_DRAIN);
  assign div_signed_o   = signed_q;
  assign div_op1_o      = op1_q;
  assign div_op2_o      = op2_q;
  assign result_o       = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Self-checking bench for div_ctrl with a behavioural divider
//               (accepts start one cycle after it rises, done after 32
//               iterations + fixup, or quickly for a zero divisor).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid_i;
  logic        div_req_i;
  logic [1:0]  div_op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        div_start_o;
  logic        div_cancel_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic [63:0] div_result_i;
  logic        div_done_i;

  int total;
  int bad;

  div_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid_i     (ex_valid_i),
    .div_req_i      (div_req_i),
    .div_op_i       (div_op_i),
    .src1_i         (src1_i),
    .src2_i         (src2_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .div_start_o    (div_start_o),
    .div_cancel_o   (div_cancel_o),
    .div_signed_o   (div_signed_o),
    .div_op1_o      (div_op1_o),
    .div_op2_o      (div_op2_o),
    .div_result_i   (div_result_i),
    .div_done_i     (div_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural divider ----------------
  logic        m_busy;
  int          m_cnt;
  logic [63:0] m_res;

  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign div_done_i   = m_busy && (m_cnt == 0);
  assign div_result_i = div_done_i ? m_res : 64'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_res  <= 64'd0;
    end else if (div_cancel_o) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (div_start_o) begin
        m_busy <= 1'b1;
        m_cnt  <= (div_op2_o == 32'd0) ? 2 : 34;
        m_res  <= div_model(div_op1_o, div_op2_o, div_signed_o);
      end
    end else if (!div_start_o) begin
      m_busy <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0 of the request.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble,
                       output int lat, output logic [31:0] res, output int nstart,
                       output logic stall0, output logic stall_v,
                       output logic [31:0] op1, output logic [31:0] op2, output logic sgn);
    ex_valid_i = 1'b1; div_req_i = 1'b1; div_op_i = op; src1_i = a; src2_i = b;
    lat = -1; res = '0; nstart = 0; stall0 = 1'b0; stall_v = 1'b1;
    op1 = '0; op2 = '0; sgn = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) stall0 = stall_o;
      if (div_start_o) begin
        nstart++;
        op1 = div_op1_o; op2 = div_op2_o; sgn = div_signed_o;
      end
      if (result_valid_o) begin
        lat = c; res = result_o; stall_v = stall_o;
        break;
      end
      @(posedge clk); #1;
      if (scramble && c == 1) begin
        src1_i = ~a; src2_i = b + 32'd1; div_op_i = ~op;
      end
    end
    @(posedge clk); #1;
    ex_valid_i = 1'b0; div_req_i = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[8];

`ifdef DIV_CACHE_EN
  localparam int HIT_LAT    = 1;
  localparam int HIT_STARTS = 0;
`else
  localparam int HIT_LAT    = 37;
  localparam int HIT_STARTS = 36;
`endif

  initial begin
    int          lat;
    int          nstart;
    int          ncancel;
    int          nvalid;
    logic [31:0] res;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sgn;
    logic        stall0;
    logic        stall_v;

    total = 0; bad = 0;
    vecs[0] = '{2'b00, 32'd100,        32'd7,          32'd14,         37};
    vecs[1] = '{2'b10, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   37};
    vecs[2] = '{2'b01, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   37};
    vecs[3] = '{2'b00, 32'd100,        32'd0,          32'd0,          5};
    vecs[4] = '{2'b00, 32'd20,         32'd4,          32'd5,          37};
    vecs[5] = '{2'b11, 32'd100,        32'd7,          32'd2,          37};
    vecs[6] = '{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   37};
    vecs[7] = '{2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,          37};

    rst = 1'b1; ex_valid_i = 1'b0; div_req_i = 1'b0; div_op_i = 2'b00;
    src1_i = '0; src2_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_stall",  {31'd0, stall_o},        32'd0);
    chk("rst_valid",  {31'd0, result_valid_o}, 32'd0);
    chk("rst_result", result_o,                32'd0);
    chk("rst_start",  {31'd0, div_start_o},    32'd0);
    chk("rst_cancel", {31'd0, div_cancel_o},   32'd0);
    chk("rst_signed", {31'd0, div_signed_o},   32'd0);
    chk("rst_op1",    div_op1_o,               32'd0);
    chk("rst_op2",    div_op2_o,               32'd0);
    @(posedge clk); #1;

    // flush in IDLE: no start, no stall
    ex_valid_i = 1'b1; div_req_i = 1'b1; div_op_i = 2'b00; src1_i = 32'd9; src2_i = 32'd3;
    flush_i = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; ex_valid_i = 1'b0; div_req_i = 1'b0;
    @(negedge clk);
    chk("idle_flush_start", {31'd0, div_start_o}, 32'd0);
    @(posedge clk); #1;

    // table: back-to-back directed vectors, src scrambled while BUSY
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, lat, res, nstart, stall0, stall_v, op1, op2, sgn);
      chk($sformatf("v%0d_result", i),  res,                      vecs[i].exp);
      chk($sformatf("v%0d_latency", i), lat,                      vecs[i].lat);
      chk($sformatf("v%0d_starts", i),  nstart,                   vecs[i].lat - 1);
      chk($sformatf("v%0d_stall0", i),  {31'd0, stall0},          32'd1);
      chk($sformatf("v%0d_stallv", i),  {31'd0, stall_v},         32'd0);
      chk($sformatf("v%0d_op1", i),     op1,                      vecs[i].a);
      chk($sformatf("v%0d_op2", i),     op2,                      vecs[i].b);
      chk($sformatf("v%0d_signed", i),  {31'd0, sgn},             {31'd0, ~vecs[i].op[0]});
    end

    // flush 10 cycles into a BUSY divide
    ex_valid_i = 1'b1; div_req_i = 1'b1; div_op_i = 2'b00; src1_i = 32'd1000; src2_i = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    flush_i = 1'b1; ex_valid_i = 1'b0; div_req_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
    ncancel = 0; nvalid = 0; nstart = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (div_cancel_o) ncancel++;
      if (result_valid_o) nvalid++;
      if (div_start_o) nstart++;
      if (c < 2) chk($sformatf("drain_stall%0d", c), {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
    end
    chk("flush1_cancel", ncancel, 32'd2);
    chk("flush1_valid",  nvalid,  32'd0);
    chk("flush1_start",  nstart,  32'd0);
    chk("flush1_hold",   result_o, 32'd1);
    do_op(2'b00, 32'd9, 32'd3, 1'b0, lat, res, nstart, stall0, stall_v, op1, op2, sgn);
    chk("after_flush1_result",  res, 32'd3);
    chk("after_flush1_latency", lat, 32'd37);

    // flush on the same cycle as div_done_i; next request presented during DRAIN
    ex_valid_i = 1'b1; div_req_i = 1'b1; div_op_i = 2'b00; src1_i = 32'd64; src2_i = 32'd8;
    for (int c = 0; c < 36; c++) begin
      @(posedge clk); #1;
    end
    flush_i = 1'b1; ex_valid_i = 1'b0; div_req_i = 1'b0;
    @(negedge clk);
    chk("flush2_done_seen", {31'd0, div_done_i},     32'd1);
    chk("flush2_valid",     {31'd0, result_valid_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    // DRAIN for 2 cycles then IDLE: start 3 cycles later, result 37 after that
    do_op(2'b00, 32'd50, 32'd5, 1'b0, lat, res, nstart, stall0, stall_v, op1, op2, sgn);
    chk("flush2_next_stall0",  {31'd0, stall0}, 32'd0);
    chk("flush2_next_latency", lat,             32'd39);
    chk("flush2_next_result",  res,             32'd10);
    chk("flush2_next_starts",  nstart,          32'd36);

    // cache: div then mod of the same operands
    do_op(2'b00, 32'd100, 32'd7, 1'b0, lat, res, nstart, stall0, stall_v, op1, op2, sgn);
    chk("cache_fill_result", res, 32'd14);
    do_op(2'b10, 32'd100, 32'd7, 1'b0, lat, res, nstart, stall0, stall_v, op1, op2, sgn);
    chk("cache_mod_result",  res,               32'd2);
    chk("cache_mod_latency", lat,               HIT_LAT);
    chk("cache_mod_starts",  nstart,            HIT_STARTS);
    chk("cache_mod_stall0",  {31'd0, stall0},   32'd1);
    chk("cache_mod_stallv",  {31'd0, stall_v},  32'd0);

    // reset mid-operation, then the same op must take full latency
    ex_valid_i = 1'b1; div_req_i = 1'b1; div_op_i = 2'b00; src1_i = 32'd1000; src2_i = 32'd3;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; ex_valid_i = 1'b0; div_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_start",  {31'd0, div_start_o}, 32'd0);
    chk("midrst_stall",  {31'd0, stall_o},     32'd0);
    chk("midrst_result", result_o,             32'd0);
    @(posedge clk); #1;
    do_op(2'b10, 32'd100, 32'd7, 1'b0, lat, res, nstart, stall0, stall_v, op1, op2, sgn);
    chk("post_rst_result",  res,    32'd2);
    chk("post_rst_latency", lat,    32'd37);
    chk("post_rst_starts",  nstart, 32'd36);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad + 1);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
